pulse_stretch: RTL
==================

# pulse_stretch

Output-side companion to the input debouncer: it converts single-cycle event pulses from the processor core into human-visible LED blinks. Each accepted event yields one fixed-length "on" interval followed by a mandatory "off" gap, so back-to-back events remain distinguishable on a board LED. It sits between core status strobes (e.g. instruction-retired or halt pulses) and the board LED pins, clocked on the same slow board clock as the debouncer.

## Interface
- HOLD_CYC, 250, LED-on duration in clk_in cycles (250 cycles = 500 ms at 500 Hz); must be ≥1.
- GAP_CYC, 100, minimum LED-off duration between blinks in cycles; must be ≥1.
- CNT_W, 4, width of the pending-event counter (queue build only).
- clk_in  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event strobe; every cycle sampled high is one event.
- led_out  output  1  stretched, registered LED drive.
- busy  output  1  high while state ≠ IDLE.
- pend  output  CNT_W  number of queued, not-yet-shown events (constant 0 when queueing is compiled out).
- ovf  output  1  sticky flag, set when an event is lost to queue saturation; cleared only by reset.

## Operation
- States: IDLE, HOLD, GAP. One down-counter, wide enough for max(HOLD_CYC, GAP_CYC)−1.
- IDLE: led_out=0. pulse_in=1 → HOLD, counter ← HOLD_CYC−1.
- HOLD: led_out=1. Counter decrements each cycle; at counter=0 → GAP, counter ← GAP_CYC−1.
- GAP: led_out=0. Counter decrements; at counter=0 (last GAP cycle): if a new blink is due (see below) → HOLD with counter ← HOLD_CYC−1, else → IDLE.
- Blink due at GAP end: pulse_in=1 that cycle, or (queue build) pend>0.
- Queue build: pulse_in=1 in HOLD or in GAP (other than a cycle in which it directly starts the next HOLD) increments pend. At GAP end with pend>0, pend is consumed first (decremented); a simultaneous pulse_in then increments it (net unchanged). Pulses arriving in IDLE start HOLD directly and never touch pend.
- Saturation: increment at pend = 2^CNT_W−1 leaves pend unchanged and sets ovf.
- Non-queue build: pulse_in in HOLD, or in GAP before the last GAP cycle, is discarded; ovf stays 0.
- Reset value of every output: led_out=0, busy=0, pend=0, ovf=0; state=IDLE, counter=0.
- Reset mid-blink: asynchronous; led_out drops immediately, all queued events are discarded.

## Timing
- All outputs are registered; no combinational path from pulse_in to any output.
- pulse_in sampled high in IDLE at edge k → led_out=1 and busy=1 from edge k+1.
- led_out high for exactly HOLD_CYC cycles, then low for at least GAP_CYC cycles.
- Isolated event: busy high for exactly HOLD_CYC+GAP_CYC cycles.
- Back-to-back blinks (queued, or pulse on the last GAP cycle): period is exactly HOLD_CYC+GAP_CYC with no IDLE cycle inserted.
- pend update is visible the cycle after the qualifying pulse_in edge.
- HOLD_CYC=1 / GAP_CYC=1 are legal: one-cycle on/off intervals, and the counter is loaded with 0.

## Configuration
- PULSE_STRETCH_QUEUE_EN defined: pending counter, pend output and ovf logic are compiled in; every event up to saturation is eventually shown as its own blink.
- Not defined: no counter is built; pend is tied to 0 and ovf to 0; events arriving while busy are dropped, except on the last GAP cycle.

## Test plan
- Reset: assert reset mid-run with state HOLD and pend=2 → led_out, busy, pend and ovf all 0 within the same cycle; after release the block stays IDLE with pulse_in=0.
- Single event, HOLD_CYC=4, GAP_CYC=2: pulse at edge 0 → led_out=1 at edges 1–4, 0 at edges 5–6; busy=1 at edges 1–6; busy=0 at edge 7.
- Queue build, HOLD_CYC=4, GAP_CYC=2: pulses at edges 0, 1, 2 → pend goes 1, 2; three blinks starting at edges 1, 7, 13; pend=0 after edge 13; ovf=0.
- Non-queue build, same parameters: pulses at edges 0 and 2 → one blink only; a pulse on edge 6 (last GAP cycle) → second blink starts at edge 7.
- Saturation, CNT_W=2, queue build: one starting pulse, then 5 pulses during HOLD → pend=3, ovf=1; exactly 4 blinks total; ovf remains 1 until reset.
- Simultaneous consume/increment: pend=1 and pulse_in=1 on the last GAP cycle → next HOLD starts and pend stays 1.

Source files
------------

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into fixed-length LED blinks separated by a minimum off gap.
// Define PULSE_STRETCH_QUEUE_EN to count events that arrive while busy and replay them as extra blinks.
module pulse_stretch #(
  parameter int HOLD_CYC = 250,
  parameter int GAP_CYC  = 100,
  parameter int CNT_W    = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend,
  output logic             ovf
);

  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          last_gap;
  logic          due;

  assign last_gap = (state_q == GAP) && (cnt_q == '0);

`ifdef PULSE_STRETCH_QUEUE_EN
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  assign due = (pend_q != '0);

  // At a GAP end with events queued, one is consumed; a coincident pulse re-fills it.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (state_q != IDLE) begin
      if (last_gap && due) begin
        if (!pulse_in) pend_d = pend_q - CNT_W'(1);
      end else if (pulse_in && !last_gap) begin
        if (pend_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
        else                         pend_d = pend_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend = pend_q;
  assign ovf  = ovf_q;
`else
  assign due  = 1'b0;
  assign pend = '0;
  assign ovf  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (last_gap) begin
          if (pulse_in || due) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    led_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;

endmodule
